// File: rtl/move_collector_if.sv
// Handshake bundle between move_collector, the 64 square FIFOs and the move-list consumer.
// master = the collector; slave = the square units plus the consumer.
interface move_collector_if #(
    parameter int unsigned NSQ = 64,
    parameter int unsigned MVW = 19
);
    localparam int unsigned SelW = $clog2(NSQ);

    logic                start;
    logic [NSQ-1:0]      sqEmpty;
    logic [159:0]        sqData;
    logic [SelW-1:0]     sqSel;
    logic [NSQ-1:0]      rden;
    logic [MVW-1:0]      mvOut;
    logic                mvValid;
    logic                mvReady;
    logic [7:0]          mvCount;
    logic                busy;
    logic                finished;

    modport master (
        input  start, sqEmpty, sqData, mvReady,
        output sqSel, rden, mvOut, mvValid, mvCount, busy, finished
    );

    modport slave (
        output start, sqEmpty, sqData, mvReady,
        input  sqSel, rden, mvOut, mvValid, mvCount, busy, finished
    );
endinterface

// File: rtl/move_collector.sv
// Drains the 64 square FIFOs in index order and streams each valid 19-bit move slot out.
// Define MOVE_COLLECTOR_COUNT_EN to build the saturating accepted-move counter on mvCount.
module move_collector #(
    parameter int unsigned NSQ = 64,
    parameter int unsigned MVW = 19
) (
    input logic               clk,
    input logic               reset,
    move_collector_if.master  bus
);
    localparam int unsigned SelW  = $clog2(NSQ);
    localparam int unsigned Slots = 8;
    localparam int unsigned WordW = Slots * MVW;

    typedef enum logic [2:0] {StIdle, StScan, StRead, StLatch, StEmit, StFin} state_e;

    state_e            state_q;
    logic [SelW-1:0]   sel_q;
    logic [WordW-1:0]  word_q;
    logic [Slots-1:0]  mask_q;
    logic [NSQ-1:0]    rden_q;
    logic [MVW-1:0]    mv_out_q;
    logic              mv_valid_q;
    logic              busy_q;
    logic              fin_q;

    logic [Slots-1:0]  latch_mask;
    logic [2:0]        latch_idx;
    logic [MVW-1:0]    latch_slot;
    logic [2:0]        cur_idx;
    logic [Slots-1:0]  rest_mask;
    logic [2:0]        next_idx;
    logic [MVW-1:0]    next_slot;
    logic              accept;
    logic              start_ok;
    logic              unused_hi;

    function automatic logic [2:0] lowest(input logic [Slots-1:0] m);
        lowest = '0;
        for (int k = Slots - 1; k >= 0; k--) begin
            if (m[k]) lowest = 3'(k);
        end
    endfunction

    // Top byte of the FIFO word carries no slot data.
    assign unused_hi = ^bus.sqData[159:WordW];

    always_comb begin
        latch_mask = '0;
        for (int k = 0; k < Slots; k++) begin
            latch_mask[k] = ~bus.sqData[MVW * k + MVW - 1];
        end
        latch_idx  = lowest(latch_mask);
        latch_slot = bus.sqData[MVW * int'(latch_idx) +: MVW];
        cur_idx    = lowest(mask_q);
        rest_mask  = mask_q & ~(8'b1 << cur_idx);
        next_idx   = lowest(rest_mask);
        next_slot  = word_q[MVW * int'(next_idx) +: MVW];
    end

    assign accept   = mv_valid_q & bus.mvReady;
    assign start_ok = bus.start & ((state_q == StIdle) | (state_q == StFin));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            word_q     <= '0;
            mask_q     <= '0;
            rden_q     <= '0;
            mv_out_q   <= '0;
            mv_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            rden_q <= '0;
            unique case (state_q)
                StIdle, StFin: begin
                    if (bus.start) begin
                        sel_q   <= '0;
                        state_q <= StScan;
                        busy_q  <= 1'b1;
                        fin_q   <= 1'b0;
                    end
                end
                StScan: begin
                    if (!bus.sqEmpty[sel_q]) begin
                        state_q       <= StRead;
                        rden_q[sel_q] <= 1'b1;
                    end else if (sel_q == SelW'(NSQ - 1)) begin
                        state_q <= StFin;
                        busy_q  <= 1'b0;
                        fin_q   <= 1'b1;
                    end else begin
                        sel_q <= sel_q + 1'b1;
                    end
                end
                StRead: state_q <= StLatch;
                StLatch: begin
                    word_q <= bus.sqData[WordW-1:0];
                    mask_q <= latch_mask;
                    if (latch_mask == '0) begin
                        state_q <= StScan;
                    end else begin
                        state_q    <= StEmit;
                        mv_valid_q <= 1'b1;
                        mv_out_q   <= latch_slot;
                    end
                end
                StEmit: begin
                    if (accept) begin
                        mask_q <= rest_mask;
                        // Empty word: go back and re-check the same square for more words.
                        if (rest_mask == '0) begin
                            state_q    <= StScan;
                            mv_valid_q <= 1'b0;
                            mv_out_q   <= '0;
                        end else begin
                            mv_out_q <= next_slot;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MOVE_COLLECTOR_COUNT_EN
    logic [7:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (start_ok) begin
            count_q <= '0;
        end else if (accept && count_q != 8'hFF) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign bus.mvCount = count_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign bus.mvCount     = '0;
`endif

    assign bus.sqSel    = sel_q;
    assign bus.rden     = rden_q;
    assign bus.mvOut    = mv_out_q;
    assign bus.mvValid  = mv_valid_q;
    assign bus.busy     = busy_q;
    assign bus.finished = fin_q;
endmodule

// File: tb/tb_move_collector.sv
// Bench for move_collector: FIFO model per square, scoreboard of expected moves, scenario table.
module tb_move_collector;
    localparam logic [18:0] Inv = 19'h4_1234;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    move_collector_if bus ();

    move_collector dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Square FIFO model: 8-deep ring per square, normal (registered-q) read mode.
    logic [159:0] mem [64][8];
    logic [159:0] q_reg [64];
    int unsigned  wr_cnt [64];
    int unsigned  rd_ptr [64];

    initial begin
        for (int i = 0; i < 64; i++) begin
            wr_cnt[i] = 0;
            rd_ptr[i] = 0;
            q_reg[i]  = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 64; i++) begin
            if (bus.rden[i]) begin
                q_reg[i]  <= mem[i][rd_ptr[i] % 8];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        bus.sqEmpty = '0;
        for (int i = 0; i < 64; i++) bus.sqEmpty[i] = (rd_ptr[i] == wr_cnt[i]);
    end
    assign bus.sqData = q_reg[bus.sqSel];

    int vectors = 0;
    int miscompares = 0;
    int accepts = 0;
    int rden_pulses = 0;
    logic [18:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: scoreboard pops on accept, stability under backpressure, rden legality.
    logic        hold = 1'b0;
    logic [18:0] prev_out = '0;
    always @(negedge clk) begin
        if (reset) begin
            hold <= 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 64'(bus.mvValid), 64'd1);
                chk("hold_out", 64'(bus.mvOut), 64'(prev_out));
            end
            if (!bus.mvValid) chk("out_zero_when_invalid", 64'(bus.mvOut), 64'd0);
            if (bus.mvValid && bus.mvReady) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_move: got %0h, expected none", bus.mvOut);
                end else begin
                    chk("move", 64'(bus.mvOut), 64'(exp_q.pop_front()));
                end
            end
            if (bus.rden != '0) begin
                rden_pulses++;
                chk("rden_onehot", bus.rden, 64'd1 << bus.sqSel);
                chk("rden_nonempty", bus.rden & bus.sqEmpty, 64'd0);
                chk("rden_no_emit", 64'(bus.mvValid), 64'd0);
            end
            hold     <= bus.mvValid && !bus.mvReady;
            prev_out <= bus.mvOut;
        end
    end

    function automatic logic [159:0] mk(input logic [18:0] s0, s1, s2, s3, s4, s5, s6, s7);
        return {8'hA5, s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    function automatic logic [159:0] seqw(input logic [18:0] b);
        return mk(b, b + 1, b + 2, b + 3, b + 4, b + 5, b + 6, b + 7);
    endfunction

    task automatic load(input int sq, input logic [159:0] w);
        logic [18:0] s;
        mem[sq][wr_cnt[sq] % 8] = w;
        wr_cnt[sq] = wr_cnt[sq] + 1;
        for (int k = 0; k < 8; k++) begin
            s = w[19 * k +: 19];
            if (!s[18]) exp_q.push_back(s);
        end
    endtask

    task automatic run(input int exp_moves, input int exp_rden, input int exp_cycles,
                       input bit toggle, input string tag);
        int acc0;
        int rd0;
        int n;
        int exp_cnt;
        acc0 = accepts;
        rd0  = rden_pulses;
        n = 0;
        bus.mvReady = 1'b1;
        bus.start = 1'b1;
        while (n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                bus.start = 1'b0;
                chk({tag, "_first_sel"}, 64'(bus.sqSel), 64'd0);
                chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
            end
            if (n == 10) bus.start = 1'b1;   // must be ignored mid-drain
            if (n == 11) bus.start = 1'b0;
            if (toggle) bus.mvReady = ~bus.mvReady;
            if (bus.finished) break;
        end
        bus.mvReady = 1'b1;
        chk({tag, "_finished"}, 64'(bus.finished), 64'd1);
        if (exp_cycles != 0) chk({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
        chk({tag, "_moves"}, 64'(accepts - acc0), 64'(exp_moves));
        chk({tag, "_rden_pulses"}, 64'(rden_pulses - rd0), 64'(exp_rden));
`ifdef MOVE_COLLECTOR_COUNT_EN
        exp_cnt = (exp_moves > 255) ? 255 : exp_moves;
`else
        exp_cnt = 0;
`endif
        chk({tag, "_mvCount"}, 64'(bus.mvCount), 64'(exp_cnt));
        chk({tag, "_last_sel"}, 64'(bus.sqSel), 64'd63);
        chk({tag, "_not_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_left_in_sb"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    typedef struct {
        int           sq_a;
        int           n_a;
        logic [159:0] wa0;
        logic [159:0] wa1;
        int           sq_b;
        int           n_b;
        logic [159:0] wb;
        bit           toggle;
        int           exp_moves;
        int           exp_rden;
        int           exp_cycles;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{0, 0, '0, '0, 0, 0, '0, 1'b0, 0, 0, 65};
        vecs[1] = '{12, 1, mk(19'h0_0C1C, Inv, Inv, Inv, Inv, 19'h2_0D35, Inv, 19'h7_FFFF), '0,
                    0, 0, '0, 1'b0, 2, 1, 70};
        vecs[2] = '{0, 2, seqw(19'h0_0100), seqw(19'h3_0200), 0, 0, '0, 1'b1, 16, 2, 0};
        vecs[3] = '{63, 1, mk(Inv, 19'h7_FFFF, Inv, 19'h4_0000, Inv, Inv, 19'h5_5555, Inv), '0,
                    0, 0, '0, 1'b0, 0, 1, 68};
        vecs[4] = '{5, 1, mk(Inv, Inv, Inv, Inv, Inv, Inv, Inv, 19'h1_1A2B), '0,
                    40, 1, seqw(19'h0_2C00), 1'b0, 9, 2, 80};

        bus.start   = 1'b0;
        bus.mvReady = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", 64'(bus.sqSel), 64'd0);
        chk("rst_rden", bus.rden, 64'd0);
        chk("rst_valid", 64'(bus.mvValid), 64'd0);
        chk("rst_out", 64'(bus.mvOut), 64'd0);
        chk("rst_count", 64'(bus.mvCount), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_fin", 64'(bus.finished), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].n_a >= 1) load(vecs[v].sq_a, vecs[v].wa0);
            if (vecs[v].n_a >= 2) load(vecs[v].sq_a, vecs[v].wa1);
            if (vecs[v].n_b >= 1) load(vecs[v].sq_b, vecs[v].wb);
            run(vecs[v].exp_moves, vecs[v].exp_rden, vecs[v].exp_cycles, vecs[v].toggle,
                $sformatf("vec%0d", v));
            @(posedge clk);
            #1;
        end

        // Reset during EMIT with four valid slots pending and the consumer stalled.
        load(3, mk(19'h0_0311, 19'h0_0322, 19'h0_0333, 19'h0_0344, Inv, Inv, Inv, Inv));
        bus.mvReady = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k < 200 && !bus.mvValid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("rstmid_emit_reached", 64'(bus.mvValid), 64'd1);
        chk("rstmid_first_out", 64'(bus.mvOut), 64'h0_0311);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_async_valid", 64'(bus.mvValid), 64'd0);
        chk("rstmid_async_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        chk("rstmid_valid", 64'(bus.mvValid), 64'd0);
        chk("rstmid_rden", bus.rden, 64'd0);
        chk("rstmid_busy", 64'(bus.busy), 64'd0);
        chk("rstmid_count", 64'(bus.mvCount), 64'd0);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("rstmid_idle_sel", 64'(bus.sqSel), 64'd0);
        run(0, 0, 65, 1'b0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
